// File: rtl/zeroheti_pkg.sv
// Shared types and widths for the zeroheti OBI fabric.
package zeroheti_pkg;

   localparam int unsigned ObiAddrW = 32;
   localparam int unsigned ObiDataW = 32;
   localparam int unsigned ObiBeW   = ObiDataW / 8;

   typedef enum logic {
      OBI_MGR_LSU = 1'b0,
      OBI_MGR_SBA = 1'b1
   } obi_mgr_idx_e;

endpackage

// File: rtl/zeroheti_obi_arb_if.sv
// Bus bundle for the two-manager OBI arbiter: manager-side ports plus the shared subordinate port.
interface zeroheti_obi_arb_if;
   import zeroheti_pkg::*;

   logic [1:0]               mgr_req_i;
   logic [1:0]               mgr_gnt_o;
   logic [1:0][ObiAddrW-1:0] mgr_addr_i;
   logic [1:0]               mgr_we_i;
   logic [1:0][ObiBeW-1:0]   mgr_be_i;
   logic [1:0][ObiDataW-1:0] mgr_wdata_i;
   logic [1:0]               mgr_rvalid_o;
   logic [ObiDataW-1:0]      mgr_rdata_o;
   logic [1:0]               mgr_err_o;

   logic                     sbr_req_o;
   logic                     sbr_gnt_i;
   logic [ObiAddrW-1:0]      sbr_addr_o;
   logic                     sbr_we_o;
   logic [ObiBeW-1:0]        sbr_be_o;
   logic [ObiDataW-1:0]      sbr_wdata_o;
   logic                     sbr_rvalid_i;
   logic [ObiDataW-1:0]      sbr_rdata_i;
   logic                     sbr_err_i;

   // Arbiter view.
   modport slave (
      input  mgr_req_i, mgr_addr_i, mgr_we_i, mgr_be_i, mgr_wdata_i,
      output mgr_gnt_o, mgr_rvalid_o, mgr_rdata_o, mgr_err_o,
      output sbr_req_o, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o,
      input  sbr_gnt_i, sbr_rvalid_i, sbr_rdata_i, sbr_err_i
   );

   // Environment view: drives managers and models the subordinate.
   modport master (
      output mgr_req_i, mgr_addr_i, mgr_we_i, mgr_be_i, mgr_wdata_i,
      input  mgr_gnt_o, mgr_rvalid_o, mgr_rdata_o, mgr_err_o,
      input  sbr_req_o, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o,
      output sbr_gnt_i, sbr_rvalid_i, sbr_rdata_i, sbr_err_i
   );

endinterface

// File: rtl/zeroheti_id_fifo.sv
// Synchronous-reset FIFO of 1-bit transaction IDs; accepts a push while full if a pop happens in the same cycle.
module zeroheti_id_fifo #(
   parameter int unsigned Depth = 2,
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push_i,
   input  logic            data_i,
   input  logic            pop_i,
   output logic            data_o,
   output logic            full_o,
   output logic            empty_o,
   output logic [CntW-1:0] count_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Depth-1:0] mem_q;
   logic [PtrW-1:0]  wptr_q, wptr_d;
   logic [PtrW-1:0]  rptr_q, rptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             push_eff, pop_eff;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign full_o   = (count_q == CntW'(Depth));
   assign empty_o  = (count_q == '0);
   assign count_o  = count_q;
   assign data_o   = mem_q[rptr_q];

   assign pop_eff  = pop_i & ~empty_o;
   assign push_eff = push_i & (~full_o | pop_eff);

   always_comb begin
      wptr_d  = push_eff ? ptr_inc(wptr_q) : wptr_q;
      rptr_d  = pop_eff  ? ptr_inc(rptr_q) : rptr_q;
      count_d = count_q + CntW'(push_eff) - CntW'(pop_eff);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_eff) mem_q[wptr_q] <= data_i;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/zeroheti_obi_arb.sv
// Shares one OBI subordinate port between the LSU (port 0) and the debug SBA manager (port 1),
// routing in-order responses back through an ID FIFO.
module zeroheti_obi_arb
   import zeroheti_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned SbaPriority    = 0
) (
   input  logic               clk_i,
   input  logic               rst_i,
   zeroheti_obi_arb_if.slave  bus,
   output logic               busy_o,
   output logic               proto_err_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   obi_mgr_idx_e    rr_q, rr_d;
   obi_mgr_idx_e    lock_sel_q, lock_sel_d;
   obi_mgr_idx_e    sel;
   obi_mgr_idx_e    head;
   logic            lock_q, lock_d;
   logic            proto_err_q, proto_err_d;
   logic            handshake;
   logic            can_issue;
   logic            fifo_head;
   logic            fifo_full, fifo_empty;
   logic [CntW-1:0] fifo_count;
   logic            rsp_valid;

   // A stalled request keeps its port even if the other manager starts requesting meanwhile.
   always_comb begin
      sel = OBI_MGR_LSU;
      if (lock_q && bus.mgr_req_i[lock_sel_q]) begin
         sel = lock_sel_q;
      end else if (&bus.mgr_req_i) begin
         if (SbaPriority != 0) sel = OBI_MGR_SBA;
         else                  sel = (rr_q == OBI_MGR_LSU) ? OBI_MGR_SBA : OBI_MGR_LSU;
      end else if (bus.mgr_req_i[OBI_MGR_SBA]) begin
         sel = OBI_MGR_SBA;
      end
   end

   // When full, a same-cycle response frees the slot the new request will take.
   assign can_issue     = ~fifo_full | bus.sbr_rvalid_i;
   assign bus.sbr_req_o = (|bus.mgr_req_i) & can_issue;
   assign handshake     = bus.sbr_req_o & bus.sbr_gnt_i;

   assign bus.sbr_addr_o  = bus.mgr_addr_i[sel];
   assign bus.sbr_we_o    = bus.mgr_we_i[sel];
   assign bus.sbr_be_o    = bus.mgr_be_i[sel];
   assign bus.sbr_wdata_o = bus.mgr_wdata_i[sel];

   always_comb begin
      bus.mgr_gnt_o = '0;
      if (handshake) bus.mgr_gnt_o[sel] = 1'b1;
   end

   zeroheti_id_fifo #(
      .Depth (MaxOutstanding)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (handshake),
      .data_i  (sel),
      .pop_i   (bus.sbr_rvalid_i),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign head      = obi_mgr_idx_e'(fifo_head);
   assign rsp_valid = bus.sbr_rvalid_i & ~fifo_empty;

   always_comb begin
      bus.mgr_rvalid_o = '0;
      bus.mgr_err_o    = '0;
      if (rsp_valid) begin
         bus.mgr_rvalid_o[head] = 1'b1;
         bus.mgr_err_o[head]    = bus.sbr_err_i;
      end
   end

   assign bus.mgr_rdata_o = bus.sbr_rdata_i;

   always_comb begin
      rr_d        = handshake ? sel : rr_q;
      lock_d      = bus.sbr_req_o & ~bus.sbr_gnt_i;
      lock_sel_d  = lock_d ? sel : lock_sel_q;
      proto_err_d = proto_err_q | (bus.sbr_rvalid_i & fifo_empty);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q        <= OBI_MGR_LSU;
         lock_q      <= 1'b0;
         lock_sel_q  <= OBI_MGR_LSU;
         proto_err_q <= 1'b0;
      end else begin
         rr_q        <= rr_d;
         lock_q      <= lock_d;
         lock_sel_q  <= lock_sel_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign busy_o      = (fifo_count != '0);
   assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_zeroheti_obi_arb.sv
// Directed bench: a round-robin arbiter and an SBA-priority arbiter fed identical stimulus.
module tb_zeroheti_obi_arb;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy_a, busy_b, perr_a, perr_b;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   zeroheti_obi_arb_if bus_a ();
   zeroheti_obi_arb_if bus_b ();

   assign bus_b.mgr_req_i    = bus_a.mgr_req_i;
   assign bus_b.mgr_addr_i   = bus_a.mgr_addr_i;
   assign bus_b.mgr_we_i     = bus_a.mgr_we_i;
   assign bus_b.mgr_be_i     = bus_a.mgr_be_i;
   assign bus_b.mgr_wdata_i  = bus_a.mgr_wdata_i;
   assign bus_b.sbr_gnt_i    = bus_a.sbr_gnt_i;
   assign bus_b.sbr_rvalid_i = bus_a.sbr_rvalid_i;
   assign bus_b.sbr_rdata_i  = bus_a.sbr_rdata_i;
   assign bus_b.sbr_err_i    = bus_a.sbr_err_i;

   zeroheti_obi_arb #(.MaxOutstanding(2), .SbaPriority(0)) dut_rr (
      .clk_i(clk), .rst_i(rst), .bus(bus_a), .busy_o(busy_a), .proto_err_o(perr_a)
   );

   zeroheti_obi_arb #(.MaxOutstanding(2), .SbaPriority(1)) dut_pr (
      .clk_i(clk), .rst_i(rst), .bus(bus_b), .busy_o(busy_b), .proto_err_o(perr_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Apply inputs just after the falling edge; checks follow #1 later, far from the rising edge.
   task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                        input logic [31:0] rdata, input logic err);
      @(negedge clk);
      bus_a.mgr_req_i    = req;
      bus_a.sbr_gnt_i    = gnt;
      bus_a.sbr_rvalid_i = rv;
      bus_a.sbr_rdata_i  = rdata;
      bus_a.sbr_err_i    = err;
      #1;
   endtask

   initial begin
      bus_a.mgr_req_i    = '0;
      bus_a.mgr_addr_i   = '0;
      bus_a.mgr_we_i     = '0;
      bus_a.mgr_be_i     = '0;
      bus_a.mgr_wdata_i  = '0;
      bus_a.sbr_gnt_i    = 1'b0;
      bus_a.sbr_rvalid_i = 1'b0;
      bus_a.sbr_rdata_i  = '0;
      bus_a.sbr_err_i    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_gnt",    32'(bus_a.mgr_gnt_o),    32'h0);
      chk("rst_rvalid", 32'(bus_a.mgr_rvalid_o), 32'h0);
      chk("rst_err",    32'(bus_a.mgr_err_o),    32'h0);
      chk("rst_sbrreq", 32'(bus_a.sbr_req_o),    32'h0);
      chk("rst_busy",   32'(busy_a),             32'h0);
      chk("rst_perr",   32'(perr_a),             32'h0);

      // Solo LSU read
      bus_a.mgr_addr_i[0] = 32'h0000_1000;
      drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("t1_gnt",   32'(bus_a.mgr_gnt_o), 32'h1);
      chk("t1_req",   32'(bus_a.sbr_req_o), 32'h1);
      chk("t1_addr",  bus_a.sbr_addr_o,     32'h0000_1000);
      drive(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      chk("t1_rvalid", 32'(bus_a.mgr_rvalid_o), 32'h1);
      chk("t1_rdata",  bus_a.mgr_rdata_o,       32'hDEAD_BEEF);
      chk("t1_busy_inflight", 32'(busy_a), 32'h1);
      drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("t1_busy_idle", 32'(busy_a), 32'h0);

      // Conflict: last winner was port 0, so round-robin starts with port 1
      bus_a.mgr_addr_i[0] = 32'h0000_00A0;
      bus_a.mgr_addr_i[1] = 32'h0000_00A1;
      drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("t2c1_gnt_rr",  32'(bus_a.mgr_gnt_o), 32'h2);
      chk("t2c1_addr_rr", bus_a.sbr_addr_o,     32'h0000_00A1);
      chk("t2c1_gnt_pr",  32'(bus_b.mgr_gnt_o), 32'h2);
      drive(2'b11, 1'b1, 1'b1, 32'h1111, 1'b0);
      chk("t2c2_gnt_rr",    32'(bus_a.mgr_gnt_o),    32'h1);
      chk("t2c2_rvalid_rr", 32'(bus_a.mgr_rvalid_o), 32'h2);
      chk("t2c2_gnt_pr",    32'(bus_b.mgr_gnt_o),    32'h2);
      chk("t2c2_rvalid_pr", 32'(bus_b.mgr_rvalid_o), 32'h2);
      drive(2'b11, 1'b1, 1'b1, 32'h2222, 1'b0);
      chk("t2c3_gnt_rr",    32'(bus_a.mgr_gnt_o),    32'h2);
      chk("t2c3_rvalid_rr", 32'(bus_a.mgr_rvalid_o), 32'h1);
      chk("t2c3_gnt_pr",    32'(bus_b.mgr_gnt_o),    32'h2);
      drive(2'b11, 1'b1, 1'b1, 32'h3333, 1'b0);
      chk("t2c4_gnt_rr",    32'(bus_a.mgr_gnt_o),    32'h1);
      chk("t2c4_rvalid_rr", 32'(bus_a.mgr_rvalid_o), 32'h2);
      chk("t2c4_gnt_pr",    32'(bus_b.mgr_gnt_o),    32'h2);
      drive(2'b01, 1'b1, 1'b1, 32'h4444, 1'b0);
      chk("t2c5_gnt_rr",    32'(bus_a.mgr_gnt_o),    32'h1);
      chk("t2c5_rvalid_rr", 32'(bus_a.mgr_rvalid_o), 32'h1);
      chk("t2c5_gnt_pr",    32'(bus_b.mgr_gnt_o),    32'h1);
      chk("t2c5_rvalid_pr", 32'(bus_b.mgr_rvalid_o), 32'h2);
      drive(2'b00, 1'b0, 1'b1, 32'h5555, 1'b0);
      chk("t2c6_rvalid_rr", 32'(bus_a.mgr_rvalid_o), 32'h1);
      chk("t2c6_rvalid_pr", 32'(bus_b.mgr_rvalid_o), 32'h1);
      drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("t2_busy_rr", 32'(busy_a), 32'h0);
      chk("t2_busy_pr", 32'(busy_b), 32'h0);

      // Backpressure: port 0 stalls alone, port 1 joins; the stalled port must keep the bus
      bus_a.mgr_addr_i[0] = 32'h0000_00B0;
      bus_a.mgr_addr_i[1] = 32'h0000_00B1;
      drive(2'b01, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("t3c1_addr", bus_a.sbr_addr_o, 32'h0000_00B0);
      chk("t3c1_gnt",  32'(bus_a.mgr_gnt_o), 32'h0);
      for (int unsigned i = 0; i < 2; i++) begin
         drive(2'b11, 1'b0, 1'b0, 32'h0, 1'b0);
         chk("t3_stall_addr_rr", bus_a.sbr_addr_o, 32'h0000_00B0);
         chk("t3_stall_addr_pr", bus_b.sbr_addr_o, 32'h0000_00B0);
         chk("t3_stall_req",     32'(bus_a.sbr_req_o), 32'h1);
      end
      drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("t3c4_addr",   bus_a.sbr_addr_o,     32'h0000_00B0);
      chk("t3c4_gnt_rr", 32'(bus_a.mgr_gnt_o), 32'h1);
      chk("t3c4_gnt_pr", 32'(bus_b.mgr_gnt_o), 32'h1);
      drive(2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
      chk("t3_rvalid", 32'(bus_a.mgr_rvalid_o), 32'h1);
      drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);

      // Full FIFO with MaxOutstanding = 2, plus write-field forwarding
      bus_a.mgr_addr_i[0]  = 32'h0000_2000;
      bus_a.mgr_we_i[0]    = 1'b1;
      bus_a.mgr_be_i[0]    = 4'b0011;
      bus_a.mgr_wdata_i[0] = 32'hCAFE_F00D;
      drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("t4_we",    32'(bus_a.sbr_we_o), 32'h1);
      chk("t4_be",    32'(bus_a.sbr_be_o), 32'h3);
      chk("t4_wdata", bus_a.sbr_wdata_o,   32'hCAFE_F00D);
      drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("t4c2_gnt", 32'(bus_a.mgr_gnt_o), 32'h1);
      drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("t4_full_req",  32'(bus_a.sbr_req_o), 32'h0);
      chk("t4_full_gnt",  32'(bus_a.mgr_gnt_o), 32'h0);
      chk("t4_full_busy", 32'(busy_a),          32'h1);
      drive(2'b01, 1'b1, 1'b1, 32'h3333, 1'b0);
      chk("t4_pp_req",    32'(bus_a.sbr_req_o),    32'h1);
      chk("t4_pp_gnt",    32'(bus_a.mgr_gnt_o),    32'h1);
      chk("t4_pp_rvalid", 32'(bus_a.mgr_rvalid_o), 32'h1);
      drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("t4_still_full_req", 32'(bus_a.sbr_req_o), 32'h0);
      drive(2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
      chk("t4_drain1", 32'(bus_a.mgr_rvalid_o), 32'h1);
      drive(2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
      chk("t4_drain2", 32'(bus_a.mgr_rvalid_o), 32'h1);
      drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("t4_busy", 32'(busy_a), 32'h0);
      chk("t4_perr", 32'(perr_a), 32'h0);
      bus_a.mgr_we_i = '0;

      // SBA read with error response
      bus_a.mgr_addr_i[1] = 32'h0000_5000;
      drive(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("t5_gnt", 32'(bus_a.mgr_gnt_o), 32'h2);
      drive(2'b00, 1'b0, 1'b1, 32'h0000_0BAD, 1'b1);
      chk("t5_rvalid", 32'(bus_a.mgr_rvalid_o), 32'h2);
      chk("t5_err",    32'(bus_a.mgr_err_o),    32'h2);
      chk("t5_rdata",  bus_a.mgr_rdata_o,       32'h0000_0BAD);
      drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("t5_err_idle", 32'(bus_a.mgr_err_o), 32'h0);

      // Spurious response on an empty FIFO
      drive(2'b00, 1'b0, 1'b1, 32'h0, 1'b1);
      chk("t6_rvalid", 32'(bus_a.mgr_rvalid_o), 32'h0);
      chk("t6_err",    32'(bus_a.mgr_err_o),    32'h0);
      drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("t6_perr_set", 32'(perr_a), 32'h1);
      drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("t6_perr_sticky", 32'(perr_a), 32'h1);
      drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
      drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("t6_busy_pre_rst", 32'(busy_a), 32'h1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t6_perr_clr", 32'(perr_a), 32'h0);
      chk("t6_busy_clr", 32'(busy_a), 32'h0);
      // The response of the transaction forgotten by reset now arrives late
      drive(2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
      chk("t6_late_rvalid", 32'(bus_a.mgr_rvalid_o), 32'h0);
      drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("t6_late_perr", 32'(perr_a), 32'h1);
      chk("t6_pr_perr",   32'(perr_b), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
